// File: rtl/alu_pkg.sv
// alu_pkg: shared types and funct decode for the HI/LO multiply/divide unit
package alu_pkg;
   typedef enum logic [2:0] {
      MDU_NOP   = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_t;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} mdu_state_t;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   function automatic mdu_op_t decode_funct(input logic [5:0] funct);
      return funct == FUNCT_MULT  ? MDU_MULT  :
             funct == FUNCT_MULTU ? MDU_MULTU :
             funct == FUNCT_DIV   ? MDU_DIV   :
             funct == FUNCT_DIVU  ? MDU_DIVU  :
             funct == FUNCT_MTHI  ? MDU_MTHI  :
             funct == FUNCT_MTLO  ? MDU_MTLO  : MDU_NOP;
   endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring divider, one unsigned quotient bit per step
module mdu_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);
   logic [WIDTH-1:0] dsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   // quo starts as the dividend and shifts its bits into rem as quotient bits fill in from the right
   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, dsr};
   // a borrow out of the trial subtraction means restore (keep the shifted remainder)
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         quo <= '0;
         rem <= '0;
         dsr <= '0;
      end else if (load) begin
         quo <= dividend;
         rem <= '0;
         dsr <= divisor;
      end else if (step) begin
         rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO
module mult_div_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  mdu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   mdu_state_t         state, state_n;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   mcand, abs_a, abs_b, quo, rem, quo_s, rem_s, res_hi, res_lo;
   logic [WIDTH:0]     sum;
   logic               is_mul, is_div, sgn, a_neg, b_neg, accept, neg_q, neg_r, dz, div_r;
   assign is_mul = op == MDU_MULT || op == MDU_MULTU;
   assign is_div = op == MDU_DIV || op == MDU_DIVU;
   assign sgn    = op == MDU_MULT || op == MDU_DIV;
   assign a_neg  = sgn && a[WIDTH-1];
   assign b_neg  = sgn && b[WIDTH-1];
   assign abs_a  = a_neg ? -a : a;
   assign abs_b  = b_neg ? -b : b;
   // FIXUP has busy low, so a new request can be taken on the same edge that writes HI/LO
   assign busy   = state == S_MUL || state == S_DIV;
   assign accept = start && !busy;
   // shift-add step: multiplier sits in the low half of prod and is consumed LSB first
   assign sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? mcand : {WIDTH{1'b0}}};
   assign prod_s = neg_q ? -prod : prod;
   assign quo_s  = neg_q ? -quo : quo;
   assign rem_s  = neg_r ? -rem : rem;
   // divide by zero: the divider naturally leaves rem = |a|, and neg_r restores a's sign
   assign res_hi = div_r ? rem_s : prod_s[2*WIDTH-1:WIDTH];
   assign res_lo = div_r ? (dz ? {WIDTH{1'b1}} : quo_s) : prod_s[WIDTH-1:0];
   mdu_div_core #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (accept && is_div),
      .step     (state == S_DIV),
      .dividend (abs_a),
      .divisor  (abs_b),
      .quo      (quo),
      .rem      (rem)
   );
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_n;
   // next state: iterate until the counter hits zero, otherwise look for a new request
   always_comb begin
      state_n = state;
      case (state)
         S_MUL, S_DIV: state_n = cnt == '0 ? S_FIXUP : state;
         default:      state_n = (start && is_mul) ? S_MUL : (start && is_div) ? S_DIV : S_IDLE;
      endcase
   end
   // operand latching, multiply iteration, result write-back and MTHI/MTLO
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         prod        <= '0;
         mcand       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz          <= 1'b0;
         div_r       <= 1'b0;
      end else begin
         done <= state == S_FIXUP;
         if (busy && cnt != '0) cnt <= cnt - CW'(1);
         if (state == S_MUL) prod <= {sum, prod[WIDTH-1:1]};
         if (state == S_FIXUP) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= dz;
         end
         if (accept && (is_mul || is_div)) begin
            cnt   <= CW'(WIDTH-1);
            mcand <= abs_a;
            prod  <= {{WIDTH{1'b0}}, abs_b};
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg && is_div;
            dz    <= is_div && b == '0;
            div_r <= is_div;
         end
         if (accept && op == MDU_MTHI) hi <= a;
         if (accept && op == MDU_MTLO) lo <= a;
      end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed table-driven bench for mult_div_unit
module tb_mult_div_unit;
   import alu_pkg::*;
   typedef struct {
      mdu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   mdu_op_t     op = MDU_NOP;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;
   int          total = 0;
   int          bad = 0;
   int          bcnt, dcnt, dedge, unstable;
   logic [31:0] r_hi, r_lo;
   logic        r_dz;
   vec_t        vecs[14];
   mult_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic run_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y, input bit hold);
      logic [31:0] h0, l0;
      @(negedge clk);
      h0 = hi;
      l0 = lo;
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = hold;
      bcnt = 0;
      dcnt = 0;
      dedge = -1;
      unstable = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (dedge < 0) begin
               dedge = i - 1;
               r_hi = hi;
               r_lo = lo;
               r_dz = div_by_zero;
            end
         end else if (dcnt == 0 && (hi !== h0 || lo !== l0)) unstable++;
         start = hold && busy;
      end
   endtask
   task automatic check_run(input string name, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      check({name, " done_edge"}, 64'(dedge), 64'd33);
      check({name, " done_count"}, 64'(dcnt), 64'd1);
      check({name, " busy_cycles"}, 64'(bcnt), 64'd32);
      check({name, " hilo_stable"}, 64'(unstable), 64'd0);
      check({name, " hi"}, {32'd0, r_hi}, {32'd0, ehi});
      check({name, " lo"}, {32'd0, r_lo}, {32'd0, elo});
      check({name, " div_by_zero"}, {63'd0, r_dz}, {63'd0, edz});
   endtask
   initial begin
      vecs[0]  = '{MDU_MULT,  32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0};
      vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFB, 32'h00000002, 32'h00000001, 32'hFFFFFFF6, 1'b0};
      vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      vecs[4]  = '{MDU_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6]  = '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
      vecs[7]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[8]  = '{MDU_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[9]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
      vecs[11] = '{MDU_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
      vecs[12] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[13] = '{MDU_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      repeat (2) @(negedge clk);
      check("reset hi", {32'd0, hi}, 64'd0);
      check("reset lo", {32'd0, lo}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset div_by_zero", {63'd0, div_by_zero}, 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         check_run($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dz);
      end
      // MTHI: one-cycle write, LO untouched, no done
      @(negedge clk);
      op = MDU_MTHI;
      a = 32'h00001234;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("mthi hi", {32'd0, hi}, 64'h1234);
      check("mthi lo", {32'd0, lo}, 64'h0);
      check("mthi done", {63'd0, done}, 64'd0);
      check("mthi busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      op = MDU_MTLO;
      a = 32'h0000ABCD;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("mtlo lo", {32'd0, lo}, 64'hABCD);
      check("mtlo hi", {32'd0, hi}, 64'h1234);
      // unused opcode does nothing
      @(negedge clk);
      op = mdu_op_t'(3'd7);
      a = 32'hDEADBEEF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("nop busy", {63'd0, busy}, 64'd0);
      check("nop hi", {32'd0, hi}, 64'h1234);
      check("nop lo", {32'd0, lo}, 64'hABCD);
      // start held through busy yields a single result
      run_op(MDU_MULTU, 32'hFFFFFFFB, 32'h00000002, 1'b1);
      check_run("hold", 32'h00000001, 32'hFFFFFFF6, 1'b0);
      // reset part way through a MULT clears everything immediately
      @(negedge clk);
      op = MDU_MULT;
      a = 32'hFFFFFFFB;
      b = 32'h00000002;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset hi", {32'd0, hi}, 64'd0);
      check("midreset lo", {32'd0, lo}, 64'd0);
      check("midreset busy", {63'd0, busy}, 64'd0);
      check("midreset done", {63'd0, done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("post reset quiet", 64'(dcnt), 64'd0);
      run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0);
      check_run("after reset", 32'd2, 32'd14, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
